// File: rtl/seg7_reader.sv
// seg7_reader -- two-digit 7-segment bus monitor.
//
// Watches the tens and units segment buses, waits until both hold the same
// pattern for STABLE_CYCLES matching samples, then decodes the frame back to
// BCD and binary and reports it once with a one-cycle o_Valid strobe.
//
// Parameters:
//   STABLE_CYCLES  matching samples needed to accept a frame (>=1)
//   SEG_ACTIVE_LOW 1: segment lit when bus bit is 0
//
// Ports:
//   i_Clk, i_Rst_L       clock, async active-low reset
//   i_Segments1/2        tens/units buses {G,F,E,D,C,B,A} (may be async)
//   o_Tens, o_Units      decoded BCD digits of the reported frame
//   o_Value              10*o_Tens + o_Units
//   o_Valid              one-cycle strobe for a newly reported frame
//   o_Error              reported frame contained an illegal pattern
//   o_Frame_Count        accepted frames, saturating
//   o_Seq_Error          sticky count-sequence fault
//
// Optional feature: define SEG7_READER_SEQ_CHECK_EN to build the sequence
// checker; otherwise o_Seq_Error is tied low.

// Per-digit decoder: lit pattern -> BCD digit + illegal flag.
module seg7_reader_dec #(
  parameter bit BLANK_OK = 1'b0  // blank digit decodes to 0 without error
) (
  input  logic [6:0] i_Lit,
  output logic [3:0] o_Digit,
  output logic       o_Err
);
  always_comb begin
    o_Digit = 4'd0;
    o_Err   = 1'b0;
    case (i_Lit)
      7'h3F: o_Digit = 4'd0;
      7'h06: o_Digit = 4'd1;
      7'h5B: o_Digit = 4'd2;
      7'h4F: o_Digit = 4'd3;
      7'h66: o_Digit = 4'd4;
      7'h6D: o_Digit = 4'd5;
      7'h7D: o_Digit = 4'd6;
      7'h07: o_Digit = 4'd7;
      7'h7F: o_Digit = 4'd8;
      7'h6F: o_Digit = 4'd9;
      7'h00: o_Err   = !BLANK_OK;
      default: o_Err = 1'b1;
    endcase
  end
endmodule

module seg7_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [6:0]  i_Segments1,
  input  logic [6:0]  i_Segments2,
  output logic [3:0]  o_Tens,
  output logic [3:0]  o_Units,
  output logic [6:0]  o_Value,
  output logic        o_Valid,
  output logic        o_Error,
  output logic [15:0] o_Frame_Count,
  output logic        o_Seq_Error
);
  localparam int NUM_LANES = 2;  // lane 1 = tens, lane 0 = units
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_SETTLE, S_REPORT, S_HOLD} state_t;

  logic [NUM_LANES-1:0][6:0] w_bus, w_lit;
  logic [NUM_LANES-1:0][6:0] r_sync1, r_sync2, r_prev, r_last_pat;
  logic [NUM_LANES-1:0][3:0] w_digit;
  logic [NUM_LANES-1:0]      w_derr;
  logic [2:0]                r_vld_pipe;
  logic                      r_have_last;
  logic [CW-1:0]             r_cnt, w_cnt_nxt;
  state_t                    r_state, w_state_nxt;
  logic                      w_match, w_load, w_err;
  logic [6:0]                w_val;

  assign w_bus = {i_Segments1, i_Segments2};

  // Sync chain plus a previous-sample register. r_vld_pipe marks when each
  // stage holds real post-reset data, so the reset-cleared zeros in the chain
  // are never counted as a stable frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_sync1    <= w_bus;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_vld_pipe <= {r_vld_pipe[1:0], 1'b1};
    end
  end

  assign w_lit = SEG_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      seg7_reader_dec #(.BLANK_OK(g == 1)) u_dec (
        .i_Lit   (w_lit[g]),
        .o_Digit (w_digit[g]),
        .o_Err   (w_derr[g])
      );
    end
  endgenerate

  assign w_err = |w_derr;
  assign w_val = 7'({3'd0, w_digit[1]} * 7'd10 + {3'd0, w_digit[0]});

  // Stability counter
  assign w_match = r_vld_pipe[2] && (r_sync2 == r_prev);

  always_comb begin
    w_cnt_nxt = '0;
    if (w_match) w_cnt_nxt = (r_cnt == SC) ? r_cnt : r_cnt + 1'b1;
  end

  // FSM next state. The frame is loaded on the edge that enters S_REPORT,
  // so o_Valid is high exactly while the FSM sits in S_REPORT.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_SETTLE: begin
        if (w_match && w_cnt_nxt == SC) begin
          if (r_have_last && r_sync2 == r_last_pat) begin
            w_state_nxt = S_HOLD;      // returned to the last frame: silent
          end else begin
            w_state_nxt = S_REPORT;
            w_load      = 1'b1;
          end
        end
      end
      // A change during the report cycle restarts settling so the new
      // pattern is not stranded in S_HOLD.
      S_REPORT: w_state_nxt = w_match ? S_HOLD : S_SETTLE;
      S_HOLD:   if (!w_match) w_state_nxt = S_SETTLE;
      default:  w_state_nxt = S_SETTLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= S_SETTLE;
      r_cnt         <= '0;
      r_last_pat    <= '0;
      r_have_last   <= 1'b0;
      o_Tens        <= '0;
      o_Units       <= '0;
      o_Value       <= '0;
      o_Valid       <= 1'b0;
      o_Error       <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_Valid <= w_load;
      if (w_load) begin
        r_last_pat  <= r_sync2;
        r_have_last <= 1'b1;
        o_Tens      <= w_digit[1];
        o_Units     <= w_digit[0];
        o_Value     <= w_val;
        o_Error     <= w_err;
        if (o_Frame_Count != 16'hFFFF) o_Frame_Count <= o_Frame_Count + 16'd1;
      end
    end
  end

`ifdef SEG7_READER_SEQ_CHECK_EN
  // Each error-free frame must follow the previous error-free one by +1
  // mod 100; the first after reset and value 0 (stopwatch cleared) pass.
  logic       r_have_val, r_seq_err;
  logic [6:0] r_last_val, w_exp_val;

  assign w_exp_val = (r_last_val == 7'd99) ? 7'd0 : r_last_val + 7'd1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_have_val <= 1'b0;
      r_last_val <= '0;
      r_seq_err  <= 1'b0;
    end else if (w_load && !w_err) begin
      if (r_have_val && w_val != 7'd0 && w_val != w_exp_val) r_seq_err <= 1'b1;
      r_last_val <= w_val;
      r_have_val <= 1'b1;
    end
  end

  assign o_Seq_Error = r_seq_err;
`else
  assign o_Seq_Error = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;
  localparam int SC = 4;
`ifdef SEG7_READER_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg1, seg2;
  logic [3:0]  o_Tens, o_Units;
  logic [6:0]  o_Value;
  logic        o_Valid, o_Error, o_Seq_Error;
  logic [15:0] o_Frame_Count;

  int n_cmp = 0;
  int n_err = 0;
  int nval  = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Segments1   (seg1),
    .i_Segments2   (seg2),
    .o_Tens        (o_Tens),
    .o_Units       (o_Units),
    .o_Value       (o_Value),
    .o_Valid       (o_Valid),
    .o_Error       (o_Error),
    .o_Frame_Count (o_Frame_Count),
    .o_Seq_Error   (o_Seq_Error)
  );

  logic [6:0] LIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Board-level raw bus value for a digit (active low).
  function automatic logic [6:0] raw(input int d);
    return ~LIT[d];
  endfunction

  function automatic void decode(input logic [6:0] r, input bit blank_ok,
                                 output int d, output bit err);
    logic [6:0] lit;
    lit = ~r;
    d = 0;
    err = 1'b1;
    for (int i = 0; i < 10; i++) if (lit == LIT[i]) begin d = i; err = 1'b0; end
    if (lit == 7'h00 && blank_ok) err = 1'b0;
  endfunction

  // ---- behavioural model ----
  // A frame is seen once SC+1 consecutive edges sampled the same bus value;
  // the two-flop synchronizer delays that decision by two edges. A frame equal
  // to the last reported one is not reported again.
  logic [13:0] qb[$];
  int          qr[$];
  logic [13:0] last_b, rep_pat;
  bit          have_b, have_rep, have_val;
  int          run, last_val;
  int          m_tens, m_units, m_value, m_cnt;
  bit          m_valid, m_err, m_seq;

  always @(posedge clk) begin
    logic [13:0] b, pb;
    int pr, t, u;
    bit et, eu;
    if (!rst_n) begin
      qb.delete(); qr.delete();
      have_b = 0; have_rep = 0; have_val = 0; run = 0; last_val = 0;
      m_tens = 0; m_units = 0; m_value = 0; m_cnt = 0;
      m_valid = 0; m_err = 0; m_seq = 0;
    end else begin
      b = {seg1, seg2};
      run = (have_b && b == last_b) ? run + 1 : 1;
      last_b = b;
      have_b = 1;
      qb.push_back(b);
      qr.push_back(run);
      m_valid = 0;
      if (qb.size() > 2) begin
        pb = qb.pop_front();
        pr = qr.pop_front();
        if (pr == SC + 1 && !(have_rep && pb == rep_pat)) begin
          decode(pb[13:7], 1'b1, t, et);
          decode(pb[6:0], 1'b0, u, eu);
          m_valid = 1; m_tens = t; m_units = u; m_value = 10 * t + u;
          m_err = et | eu;
          if (m_cnt < 65535) m_cnt++;
          rep_pat = pb; have_rep = 1;
          if (SEQ_EN && !m_err) begin
            if (have_val && m_value != 0 && m_value != (last_val + 1) % 100) m_seq = 1;
            last_val = m_value; have_val = 1;
          end
        end
      end
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (o_Valid) nval++;
    if (!rst_n) begin
      chk("rst_valid", o_Valid, 0);
      chk("rst_outs", {o_Tens, o_Units, o_Value, o_Error, o_Seq_Error}, 0);
      chk("rst_count", o_Frame_Count, 0);
    end else begin
      chk("valid", o_Valid, m_valid);
      chk("tens", o_Tens, m_tens);
      chk("units", o_Units, m_units);
      chk("value", o_Value, m_value);
      chk("error", o_Error, m_err);
      chk("count", o_Frame_Count, m_cnt);
      chk("seq_err", o_Seq_Error, m_seq);
    end
  end

  // ---- directed stimulus ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [6:0] t, input logic [6:0] u);
    seg1 = t; seg2 = u;
  endtask

  // Counts edges from the first edge after the current drive until o_Valid
  // is seen; leaves the bench at that negedge.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!o_Valid && n < 40);
    if (!o_Valid) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, v0;
    rst_n = 1'b0;
    drive(7'h7F, 7'h7F);
    // Reset with buses toggling
    repeat (6) begin
      tick();
      drive(7'($urandom), 7'($urandom));
    end
    chk("lit_rst_count", o_Frame_Count, 0);
    chk("lit_rst_valid", nval, 0);

    // Release with both buses blank: tens blank is legal, units blank is not
    drive(7'h7F, 7'h7F);
    tick();
    rst_n = 1'b1;
    wait_valid("first", n);
    chk("lit_first_lat", n, SC + 3);
    chk("lit_first_digits", {o_Tens, o_Units, o_Value}, 0);
    chk("lit_first_err", o_Error, 1);
    chk("lit_first_count", o_Frame_Count, 1);

    // "29"
    repeat (3) tick();
    drive(raw(2), raw(9));
    wait_valid("d29", n);
    chk("lit_29_lat", n, SC + 3);
    chk("lit_29_tens", o_Tens, 2);
    chk("lit_29_units", o_Units, 9);
    chk("lit_29_value", o_Value, 29);
    chk("lit_29_err", o_Error, 0);

    // Glitch to "88" for two cycles and back
    repeat (8) tick();
    v0 = nval;
    drive(raw(8), raw(8));
    tick(); tick();
    drive(raw(2), raw(9));
    repeat (15) tick();
    chk("lit_glitch_valids", nval - v0, 0);
    chk("lit_glitch_count", o_Frame_Count, 2);

    // Illegal: tens "1", units blank
    drive(raw(1), 7'h7F);
    wait_valid("illegal", n);
    chk("lit_ill_tens", o_Tens, 1);
    chk("lit_ill_units", o_Units, 0);
    chk("lit_ill_value", o_Value, 10);
    chk("lit_ill_err", o_Error, 1);
    tick();

    // Pattern changes every 3 cycles: never stable long enough
    v0 = nval;
    for (int i = 0; i < 50; i++) begin
      if (i % 3 == 0) drive(raw(3), raw((i / 3) % 10));
      tick();
    end
    chk("lit_cont_valids", nval - v0, 0);
    chk("lit_cont_count", o_Frame_Count, 3);

    // Reset mid-settle
    drive(raw(7), raw(7));
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_count", o_Frame_Count, 0);
    chk("lit_midrst_valid", o_Valid, 0);
    drive(raw(4), raw(1));
    tick();
    rst_n = 1'b1;

    // Sequence 41 -> 42 -> 44 -> 00
    wait_valid("s41", n);
    chk("lit_41_value", o_Value, 41);
    chk("lit_41_count", o_Frame_Count, 1);
    tick();
    drive(raw(4), raw(2));
    wait_valid("s42", n);
    chk("lit_42_seq", o_Seq_Error, 0);
    tick();
    drive(raw(4), raw(4));
    wait_valid("s44", n);
    chk("lit_44_value", o_Value, 44);
    chk("lit_44_seq", o_Seq_Error, SEQ_EN ? 1 : 0);
    tick();
    drive(raw(0), raw(0));
    wait_valid("s00", n);
    chk("lit_00_value", o_Value, 0);
    chk("lit_00_seq", o_Seq_Error, SEQ_EN ? 1 : 0);
    chk("lit_00_count", o_Frame_Count, 4);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
